// File: rtl/elevator_pkg.sv
// Shared types and default sizing for the elevator scheduler slice.
package elevator_pkg;

    localparam int ELEV_NUM_FLOORS  = 4;
    localparam int ELEV_FLOOR_W     = 2;
    localparam int ELEV_DOOR_CYCLES = 16;

    // Floor index at the default building size.
    typedef logic [ELEV_FLOOR_W-1:0] floor_t;

    // Scheduler states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        MOVING    = 2'd1,
        DOOR_OPEN = 2'd2
    } state_e;

endpackage

// File: rtl/elevator_req_mask.sv
// Classifies latched requests relative to a floor: any above, any below, one here.
module elevator_req_mask
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = ELEV_NUM_FLOORS,
    parameter int FLOOR_W    = ELEV_FLOOR_W
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    floor,
    output logic                  above,
    output logic                  below,
    output logic                  here
);

    logic [NUM_FLOORS-1:0] gt_mask_s;
    logic [NUM_FLOORS-1:0] lt_mask_s;

    // Thermometer masks of the floors strictly above and strictly below the reference.
    always_comb begin
        gt_mask_s = {NUM_FLOORS{1'b0}};
        lt_mask_s = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            gt_mask_s[i] = (i > int'(floor));
            lt_mask_s[i] = (i < int'(floor));
        end
    end

    assign above = |(pending & gt_mask_s);
    assign below = |(pending & lt_mask_s);
    assign here  = pending[floor];

endmodule

// File: rtl/elevator_scheduler_chk.sv
// Simulation-only property checks on the step command interface.
module elevator_scheduler_chk
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = ELEV_NUM_FLOORS,
    parameter int FLOOR_W    = ELEV_FLOOR_W
) (
    input logic               clk,
    input logic               reset_n,
    input logic               step_req,
    input logic               step_up,
    input logic               step_done,
    input logic [FLOOR_W-1:0] car_floor
);

    localparam logic [FLOOR_W-1:0] TOP_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

    a_no_overrun_up: assert property (@(posedge clk) disable iff (!reset_n)
        (step_req && step_done && step_up) |-> (car_floor != TOP_FLOOR));

    a_no_overrun_dn: assert property (@(posedge clk) disable iff (!reset_n)
        (step_req && step_done && !step_up) |-> (car_floor != {FLOOR_W{1'b0}}));

    a_dir_stable: assert property (@(posedge clk) disable iff (!reset_n)
        step_req |=> (!step_req || $stable(step_up)));

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN-order car scheduler: latches floor calls, steps the car one floor at a
// time through a req/done handshake and holds the door open at each stop.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS  = ELEV_NUM_FLOORS,
    parameter int FLOOR_W     = ELEV_FLOOR_W,
    parameter int DOOR_CYCLES = ELEV_DOOR_CYCLES
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic                  door_hold,
    input  logic                  step_done,
    output logic                  step_req,
    output logic                  step_up,
    output logic [FLOOR_W-1:0]    car_floor,
    output logic                  door_open,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  busy
);

    localparam int                 TIMER_W    = $clog2(DOOR_CYCLES);
    localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR  = FLOOR_W'(NUM_FLOORS - 1);

    state_e                state_r;
    logic [FLOOR_W-1:0]    car_floor_r;
    logic [NUM_FLOORS-1:0] pending_r;
    logic                  dir_up_r;
    logic                  step_req_r;
    logic                  step_up_r;
    logic                  door_open_r;
    logic                  busy_r;
    logic [TIMER_W-1:0]    timer_r;

    state_e                state_nxt_s;
    logic [FLOOR_W-1:0]    floor_nxt_s;
    logic                  dir_nxt_s;
    logic [TIMER_W-1:0]    timer_nxt_s;
    logic [NUM_FLOORS-1:0] pending_nxt_s;
    logic [NUM_FLOORS-1:0] clr_s;
    logic [FLOOR_W-1:0]    new_floor_s;
    logic                  arrived_s;
    logic                  reload_s;
    logic [FLOOR_W-1:0]    mask_floor_s;
    logic [NUM_FLOORS-1:0] mask_pend_s;
    logic                  above_s;
    logic                  below_s;
    logic                  here_s;

    assign arrived_s = (state_r == MOVING) && step_done;
    assign reload_s  = door_hold || call_req[car_floor_r];

    // Floor the car reaches when the current step completes, clamped at both ends.
    always_comb begin
        new_floor_s = car_floor_r;
        if (dir_up_r) begin
            if (car_floor_r != TOP_FLOOR) begin
                new_floor_s = car_floor_r + FLOOR_W'(1);
            end else begin
                new_floor_s = car_floor_r;
            end
        end else begin
            if (car_floor_r != {FLOOR_W{1'b0}}) begin
                new_floor_s = car_floor_r - FLOOR_W'(1);
            end else begin
                new_floor_s = car_floor_r;
            end
        end
    end

    // On arrival the stop decision looks at the new floor and includes calls
    // arriving this very cycle, so a same-cycle call at that floor is picked up.
    always_comb begin
        if (arrived_s) begin
            mask_floor_s = new_floor_s;
            mask_pend_s  = pending_r | call_req;
        end else begin
            mask_floor_s = car_floor_r;
            mask_pend_s  = pending_r;
        end
    end

    elevator_req_mask #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_req_mask (
        .pending (mask_pend_s),
        .floor   (mask_floor_s),
        .above   (above_s),
        .below   (below_s),
        .here    (here_s)
    );

    // Calls at the floor whose door is open are absorbed rather than latched.
    always_comb begin
        if (state_r == DOOR_OPEN) begin
            clr_s = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << car_floor_r;
        end else begin
            clr_s = {NUM_FLOORS{1'b0}};
        end
        pending_nxt_s = (pending_r | call_req) & ~clr_s;
    end

    // Next-state, direction, floor and door-timer decisions.
    always_comb begin
        state_nxt_s = state_r;
        floor_nxt_s = car_floor_r;
        dir_nxt_s   = dir_up_r;
        timer_nxt_s = timer_r;
        case (state_r)
            IDLE: begin
                if (here_s) begin
                    state_nxt_s = DOOR_OPEN;
                    timer_nxt_s = TIMER_LOAD;
                end else if (above_s && (dir_up_r || !below_s)) begin
                    state_nxt_s = MOVING;
                    dir_nxt_s   = 1'b1;
                end else if (below_s) begin
                    state_nxt_s = MOVING;
                    dir_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            MOVING: begin
                if (step_done) begin
                    floor_nxt_s = new_floor_s;
                    if (here_s) begin
                        state_nxt_s = DOOR_OPEN;
                        timer_nxt_s = TIMER_LOAD;
                    end else if (dir_up_r ? above_s : below_s) begin
                        state_nxt_s = MOVING;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = MOVING;
                end
            end
            DOOR_OPEN: begin
                if (reload_s) begin
                    timer_nxt_s = TIMER_LOAD;
                end else if (timer_r != {TIMER_W{1'b0}}) begin
                    timer_nxt_s = timer_r - TIMER_W'(1);
                end else if (dir_up_r ? above_s : below_s) begin
                    state_nxt_s = MOVING;
                end else if (dir_up_r ? below_s : above_s) begin
                    state_nxt_s = MOVING;
                    dir_nxt_s   = ~dir_up_r;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State, position, request latch and registered command outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            car_floor_r <= {FLOOR_W{1'b0}};
            pending_r   <= {NUM_FLOORS{1'b0}};
            dir_up_r    <= 1'b1;
            step_req_r  <= 1'b0;
            step_up_r   <= 1'b0;
            door_open_r <= 1'b0;
            busy_r      <= 1'b0;
            timer_r     <= {TIMER_W{1'b0}};
        end else begin
            state_r     <= state_nxt_s;
            car_floor_r <= floor_nxt_s;
            pending_r   <= pending_nxt_s;
            dir_up_r    <= dir_nxt_s;
            step_req_r  <= (state_nxt_s == MOVING);
            step_up_r   <= (state_nxt_s == MOVING) && dir_nxt_s;
            door_open_r <= (state_nxt_s == DOOR_OPEN);
            busy_r      <= (state_nxt_s != IDLE);
            timer_r     <= timer_nxt_s;
        end
    end

    assign step_req  = step_req_r;
    assign step_up   = step_up_r;
    assign car_floor = car_floor_r;
    assign door_open = door_open_r;
    assign pending   = pending_r;
    assign dir_up    = dir_up_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_elevator_scheduler.sv
// Self-checking bench for elevator_scheduler against a behavioural car model.
module tb_elevator_scheduler;
    import elevator_pkg::*;

    localparam int NF = ELEV_NUM_FLOORS;
    localparam int FW = ELEV_FLOOR_W;
    localparam int DC = ELEV_DOOR_CYCLES;

    logic          clk;
    logic          reset_n;
    logic [NF-1:0] call_req;
    logic          door_hold;
    logic          step_done;
    logic          step_req;
    logic          step_up;
    logic [FW-1:0] car_floor;
    logic          door_open;
    logic [NF-1:0] pending;
    logic          dir_up;
    logic          busy;

    elevator_scheduler #(
        .NUM_FLOORS  (NF),
        .FLOOR_W     (FW),
        .DOOR_CYCLES (DC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .call_req  (call_req),
        .door_hold (door_hold),
        .step_done (step_done),
        .step_req  (step_req),
        .step_up   (step_up),
        .car_floor (car_floor),
        .door_open (door_open),
        .pending   (pending),
        .dir_up    (dir_up),
        .busy      (busy)
    );

    elevator_scheduler_chk #(
        .NUM_FLOORS (NF),
        .FLOOR_W    (FW)
    ) u_chk (
        .clk       (clk),
        .reset_n   (reset_n),
        .step_req  (step_req),
        .step_up   (step_up),
        .step_done (step_done),
        .car_floor (car_floor)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Car model: what the car is doing, where, which way, what is owed, door time left.
    typedef enum {M_IDLE, M_TRAVEL, M_DWELL} mode_t;
    mode_t         m_mode;
    int            m_floor;
    logic [NF-1:0] m_pend;
    bit            m_dir;
    int            m_left;

    logic [NF-1:0] call_v;
    bit            hold_v;
    int            errors;
    int            checks;
    int            door_cnt;
    bit            prev_door;
    int            door_log[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit has_above(input logic [NF-1:0] p, input int f);
        for (int i = f + 1; i < NF; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit has_below(input logic [NF-1:0] p, input int f);
        for (int i = 0; i < f; i++) if (p[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_floor = 0;
        m_pend  = '0;
        m_dir   = 1'b1;
        m_left  = 0;
    endtask

    task automatic check_outputs();
        check_val("step_req",  32'(step_req),  32'(m_mode == M_TRAVEL));
        check_val("step_up",   32'(step_up),   32'((m_mode == M_TRAVEL) && m_dir));
        check_val("car_floor", 32'(car_floor), 32'(m_floor));
        check_val("door_open", 32'(door_open), 32'(m_mode == M_DWELL));
        check_val("pending",   32'(pending),   32'(m_pend));
        check_val("dir_up",    32'(dir_up),    32'(m_dir));
        check_val("busy",      32'(busy),      32'(m_mode != M_IDLE));
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic tick();
        logic [NF-1:0] calls;
        logic [NF-1:0] pp;
        bit            hold;
        bit            done;
        mode_t         nmode;
        int            nfloor;
        int            nf;
        bit            ndir;
        int            nleft;
        logic [NF-1:0] np;
        @(negedge clk);
        calls = call_v;
        hold  = hold_v;
        if (m_mode == M_TRAVEL) done = ($urandom_range(0, 2) == 0);
        else                    done = ($urandom_range(0, 15) == 0);
        call_req  = calls;
        door_hold = hold;
        step_done = done;

        nmode  = m_mode;
        nfloor = m_floor;
        ndir   = m_dir;
        nleft  = m_left;
        np     = m_pend | calls;
        if (m_mode == M_DWELL) np[m_floor] = 1'b0;
        case (m_mode)
            M_IDLE: begin
                if (m_pend[m_floor]) begin
                    nmode = M_DWELL;
                    nleft = DC;
                end else if (has_above(m_pend, m_floor) && (m_dir || !has_below(m_pend, m_floor))) begin
                    nmode = M_TRAVEL;
                    ndir  = 1'b1;
                end else if (has_below(m_pend, m_floor)) begin
                    nmode = M_TRAVEL;
                    ndir  = 1'b0;
                end
            end
            M_TRAVEL: begin
                if (done) begin
                    nf     = m_dir ? m_floor + 1 : m_floor - 1;
                    nfloor = nf;
                    pp     = m_pend | calls;
                    if (pp[nf]) begin
                        nmode = M_DWELL;
                        nleft = DC;
                    end else if (!(m_dir ? has_above(pp, nf) : has_below(pp, nf))) begin
                        nmode = M_IDLE;
                    end
                end
            end
            M_DWELL: begin
                if (hold || calls[m_floor]) begin
                    nleft = DC;
                end else if (m_left > 1) begin
                    nleft = m_left - 1;
                end else if (m_dir ? has_above(m_pend, m_floor) : has_below(m_pend, m_floor)) begin
                    nmode = M_TRAVEL;
                end else if (m_dir ? has_below(m_pend, m_floor) : has_above(m_pend, m_floor)) begin
                    nmode = M_TRAVEL;
                    ndir  = !m_dir;
                end else begin
                    nmode = M_IDLE;
                end
            end
            default: ;
        endcase

        @(posedge clk);
        #1;
        m_mode  = nmode;
        m_floor = nfloor;
        m_dir   = ndir;
        m_left  = nleft;
        m_pend  = np;
        check_outputs();
        if (door_open === 1'b1) begin
            door_cnt++;
            if (!prev_door) door_log.push_back(int'(car_floor));
        end
        prev_door = (door_open === 1'b1);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
    task automatic do_reset();
        #2;
        reset_n   = 1'b0;
        call_req  = '0;
        door_hold = 1'b0;
        step_done = 1'b0;
        #1;
        model_reset();
        check_outputs();
        prev_door = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic pulse_call(input logic [NF-1:0] c);
        call_v = c;
        tick();
        call_v = '0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        while (!(m_mode == M_IDLE && m_pend == '0) && n < budget) begin
            tick();
            n++;
        end
        check_val({tag, "_settle"}, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_travel_at(input string tag, input int floor, input int budget);
        int n;
        n = 0;
        while (!(m_mode == M_TRAVEL && m_floor == floor) && n < budget) begin
            tick();
            n++;
        end
        check_val({tag, "_reach"}, 32'(n < budget), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        errors    = 0;
        checks    = 0;
        call_v    = '0;
        hold_v    = 1'b0;
        door_cnt  = 0;
        prev_door = 1'b0;
        reset_n   = 1'b1;
        call_req  = '0;
        door_hold = 1'b0;
        step_done = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Single top-floor call: three steps up, 16-cycle dwell, back to idle.
        door_cnt = 0;
        pulse_call(4'b1000);
        check_val("s1_latched", 32'(pending), 32'd8);
        tick();
        check_val("s1_step_up", 32'({step_req, step_up}), 32'd3);
        wait_idle("s1", 300);
        check_val("s1_floor", 32'(car_floor), 32'd3);
        check_val("s1_dwell", 32'(door_cnt), 32'(DC));
        check_val("s1_busy", 32'(busy), 32'd0);

        // Call at the resting floor: door opens on the second edge, no step.
        do_reset();
        pulse_call(4'b0001);
        check_val("s2_door_early", 32'(door_open), 32'd0);
        tick();
        check_val("s2_door", 32'(door_open), 32'd1);
        check_val("s2_no_step", 32'(step_req), 32'd0);
        wait_idle("s2", 100);

        // Mid-travel pick-ups are served in order on the way up.
        do_reset();
        door_log.delete();
        pulse_call(4'b1000);
        wait_travel_at("s3", 0, 50);
        pulse_call(4'b0110);
        wait_idle("s3", 400);
        check_val("s3_stops", 32'(door_log.size()), 32'd3);
        if (door_log.size() == 3) begin
            check_val("s3_stop0", 32'(door_log[0]), 32'd1);
            check_val("s3_stop1", 32'(door_log[1]), 32'd2);
            check_val("s3_stop2", 32'(door_log[2]), 32'd3);
        end

        // A call behind the car waits until the upward sweep is finished.
        do_reset();
        door_log.delete();
        pulse_call(4'b1000);
        wait_travel_at("s4", 2, 100);
        pulse_call(4'b0001);
        wait_idle("s4", 400);
        check_val("s4_stops", 32'(door_log.size()), 32'd2);
        if (door_log.size() == 2) begin
            check_val("s4_first", 32'(door_log[0]), 32'd3);
            check_val("s4_second", 32'(door_log[1]), 32'd0);
        end
        check_val("s4_dir", 32'(dir_up), 32'd0);

        // Door hold for 40 cycles extends the dwell to 40 + 16 cycles.
        do_reset();
        door_cnt = 0;
        pulse_call(4'b0001);
        tick();
        hold_v = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        hold_v = 1'b0;
        wait_idle("s5", 100);
        check_val("s5_dwell", 32'(door_cnt), 32'(40 + DC));

        // Reset while a step is outstanding at floor 2.
        do_reset();
        pulse_call(4'b1000);
        wait_travel_at("s6", 2, 100);
        check_val("s6_stepping", 32'(step_req), 32'd1);
        do_reset();
        check_val("s6_floor", 32'(car_floor), 32'd0);
        check_val("s6_step", 32'(step_req), 32'd0);

        // Random traffic with occasional holds and one reset in the middle.
        for (int i = 0; i < 2500; i++) begin
            call_v = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
            hold_v = ($urandom_range(0, 24) == 0);
            tick();
            if (i == 1200) do_reset();
        end
        call_v = '0;
        hold_v = 1'b0;
        wait_idle("rand", 600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
